pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Pipeline scheduler for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Drives the per-stage register enables and flushes, and the EX-operand forwarding selects.
- Inserts load-use bubbles, squashes the wrong path on EX redirects, and freezes the pipe while a data-memory access waits for its acknowledge, with a timeout watchdog.
- Sits beside the main decoder; consumes the decoded RegWrite/WDSel/MemWrite/NPCOp-derived flags carried in the pipeline registers.

Parameters:
- TIMEOUT, 256, maximum number of MWAIT cycles before the timeout fault.
- CNT_W, 32, width of the stall-cycle performance counter.
- RAW, 5, register address width.

Ports:
- clk  in  1  core clock
- rstn  in  1  reset, asynchronous, active-low
- id_rs1, id_rs2  in  RAW  source registers of the ID instruction
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2
- ex_rs1, ex_rs2  in  RAW  source registers of the EX instruction
- ex_rd  in  RAW  EX destination
- ex_regwrite  in  1  EX writes the register file
- ex_wdsel  in  2  EX WDSel; 2'b01 means load
- ex_redirect  in  1  EX resolved a taken branch, jal or jalr
- mem_rd  in  RAW  MEM destination
- mem_regwrite  in  1  MEM writes the register file
- mem_is_load  in  1  MEM holds a load
- mem_req  in  1  MEM holds a load or store
- dm_ack  in  1  data memory completes the access this cycle
- wb_rd  in  RAW  WB destination
- wb_regwrite  in  1  WB writes the register file
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage register enables
- ifid_flush, idex_flush  out  1  synchronous bubble insert into IF/ID and ID/EX
- fwd_a, fwd_b  out  2  EX operand select: 00 = RF, 01 = MEM ALU result, 10 = WB data
- dm_timeout  out  1  sticky fault flag
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Registered state:
  - FSM: RUN, MWAIT, ERR.
  - wait_cnt: width clog2(TIMEOUT).
  - dm_timeout.
  - stall_cycles.
- Reset (rstn low, asynchronous): state=RUN, wait_cnt=0, dm_timeout=0, stall_cycles=0. With all inputs low, the combinational outputs are all enables=1, flushes=0, fwd=00.
- Memory freeze is Mealy: freeze = (RUN & mem_req & ~dm_ack) | MWAIT & ~dm_ack | ERR.
  - While frozen, all five enables = 0 and flushes = 0. The WB rewrite is idempotent.
  - On the dm_ack cycle all enables = 1 in that same cycle.
- FSM transitions:
  - RUN -> MWAIT when mem_req & ~dm_ack.
  - MWAIT -> RUN on dm_ack; wait_cnt clears.
  - MWAIT -> ERR when wait_cnt == TIMEOUT-1 & ~dm_ack; dm_timeout sets.
  - ERR is held until reset.
  - wait_cnt increments every MWAIT cycle and is cleared in RUN.
- Redirect (not frozen): ifid_flush=1, idex_flush=1, all enables=1 so the PC loads the target. Two-instruction penalty.
- Load-use (not frozen, no redirect):
  - Condition: ex_regwrite & ex_wdsel==01 & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Action: pc_en=0, ifid_en=0, idex_flush=1; other enables = 1. Exactly one bubble.
- Priority: freeze > redirect > load-use. A redirect together with load-use produces no stall, because the ID instruction is squashed.
- Forwarding (combinational, independent of freeze), fwd_a shown; fwd_b is the same with rs2:
  - 01 if mem_regwrite & ~mem_is_load & mem_rd!=0 & mem_rd==ex_rs1.
  - else 10 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1.
  - else 00.
  - MEM has priority over WB. x0 is never forwarded.
- stall_cycles: increments every cycle with pc_en=0, including ERR. Saturates at all-ones.

Decomposition:
- Shared package holds:
  - FWD_RF/FWD_MEM/FWD_WB encodings.
  - WDSel_FromMEM = 2'b01.
  - FSM state encoding.
- Sub-module pipe_fwd_sel: combinational forwarding for one operand, instantiated twice.

Test Plan:
- Load-use: ex_rd=5 with ex_wdsel=01, ex_regwrite=1; id_rs1=5, id_use_rs1=1 -> exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cycles goes 0->1.
- Redirect together with load-use in the same cycle -> ifid_flush=idex_flush=1 and pc_en=1; stall_cycles unchanged.
- Forward priority: mem_rd=wb_rd=ex_rs2=7, both regwrite=1, mem_is_load=0 -> fwd_b=01; then mem_is_load=1 -> 10; then ex_rs2=0 -> 00.
- Memory wait: mem_req=1, dm_ack low for 3 cycles then high -> enables 0 for 3 cycles (RUN, MWAIT, MWAIT), all 1 on the ack cycle, state back to RUN; stall_cycles +3.
- Timeout with TIMEOUT=4: mem_req=1, dm_ack never -> dm_timeout=1 in the cycle after 4 MWAIT cycles; ERR stays frozen even when dm_ack later goes high.
- Reset mid-MWAIT: drop rstn asynchronously -> state=RUN, dm_timeout=0, stall_cycles=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared encodings for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam logic [1:0] WDSEL_FROM_MEM = 2'b01;
    typedef enum logic [1:0] {RUN, MWAIT, ERR} state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// pipe_fwd_sel: EX operand forwarding select for one source register
module pipe_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RAW = 5
) (
    input  logic [RAW-1:0] ex_rs,
    input  logic [RAW-1:0] mem_rd,
    input  logic           mem_regwrite,
    input  logic           mem_is_load,
    input  logic [RAW-1:0] wb_rd,
    input  logic           wb_regwrite,
    output logic [1:0]     fwd
);
    // a load in MEM has no data yet, so only WB can supply it
    always_comb begin
        fwd = (mem_regwrite && !mem_is_load && mem_rd != '0 && mem_rd == ex_rs) ? FWD_MEM :
              (wb_regwrite && wb_rd != '0 && wb_rd == ex_rs) ? FWD_WB : FWD_RF;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stage enables, flushes, forwarding and memory-wait watchdog
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32,
    parameter int RAW     = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [RAW-1:0]   id_rs1,
    input  logic [RAW-1:0]   id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RAW-1:0]   ex_rs1,
    input  logic [RAW-1:0]   ex_rs2,
    input  logic [RAW-1:0]   ex_rd,
    input  logic             ex_regwrite,
    input  logic [1:0]       ex_wdsel,
    input  logic             ex_redirect,
    input  logic [RAW-1:0]   mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_is_load,
    input  logic             mem_req,
    input  logic             dm_ack,
    input  logic [RAW-1:0]   wb_rd,
    input  logic             wb_regwrite,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             dm_timeout,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int WCW = $clog2(TIMEOUT > 2 ? TIMEOUT : 2);

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic           freeze;
    logic           load_use;

    always_comb begin
        freeze   = (state == ERR) || (!dm_ack && (state == MWAIT || (state == RUN && mem_req)));
        load_use = ex_regwrite && ex_wdsel == WDSEL_FROM_MEM && ex_rd != '0 &&
                   ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        // a redirect squashes the ID instruction, so its load-use hazard is moot
        pc_en      = !freeze && (ex_redirect || !load_use);
        ifid_en    = pc_en;
        idex_en    = !freeze;
        exmem_en   = !freeze;
        memwb_en   = !freeze;
        ifid_flush = !freeze && ex_redirect;
        idex_flush = !freeze && (ex_redirect || load_use);
    end

    pipe_fwd_sel #(.RAW(RAW)) u_fwd_a (
        .ex_rs(ex_rs1), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_is_load(mem_is_load),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .fwd(fwd_a)
    );

    pipe_fwd_sel #(.RAW(RAW)) u_fwd_b (
        .ex_rs(ex_rs2), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_is_load(mem_is_load),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .fwd(fwd_b)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= RUN;
            wait_cnt     <= '0;
            dm_timeout   <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (!pc_en && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            case (state)
                RUN: begin
                    wait_cnt <= '0;
                    if (mem_req && !dm_ack)
                        state <= MWAIT;
                end
                MWAIT: begin
                    if (dm_ack) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
                        state      <= ERR;
                        dm_timeout <= 1'b1;
                    end else
                        wait_cnt <= wait_cnt + WCW'(1);
                end
                default: state <= ERR;
            endcase
        end
    end
endmodule
